// File: rtl/fdiv.sv
// fdiv: iterative radix-2 restoring divider for 17-bit FloPoCo floats, R = X / Y.
// Optional macro FDIV_EARLY_EXIT_EN: special-case operand pairs skip DIV/ROUND (latency 1).
module fdiv #(
  parameter int ID = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [16:0] X,
  input  logic [16:0] Y,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [16:0] R,
  output logic        out_valid,
  input  logic        out_ready
);

  typedef enum logic [1:0] {IDLE, DIV, ROUND, DONE} state_t;

  localparam logic [1:0] EXC_ZERO = 2'b00;
  localparam logic [1:0] EXC_NORM = 2'b01;
  localparam logic [1:0] EXC_INF  = 2'b10;
  localparam logic [1:0] EXC_NAN  = 2'b11;

  // ID is an instance tag only.
  if (ID < 0) begin : g_id_tag
  end

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [8:0]  rem_q, rem_d;
  logic [10:0] quo_q, quo_d;
  logic [7:0]  sig_y_q, sig_y_d;
  logic [6:0]  ex_q, ex_d;
  logic [6:0]  ey_q, ey_d;
  logic        sign_q, sign_d;
  logic        spec_q, spec_d;
  logic [2:0]  spec_hdr_q, spec_hdr_d;
  logic [16:0] r_q, r_d;

  logic [1:0]  xe, ye;
  logic        in_spec;
  logic [1:0]  in_exc;
  logic [2:0]  in_hdr;

  assign xe = X[16:15];
  assign ye = Y[16:15];

  always_comb begin
    in_spec = 1'b1;
    in_exc  = EXC_NORM;
    if (xe == EXC_NAN || ye == EXC_NAN || (xe == EXC_INF && ye == EXC_INF) ||
        (xe == EXC_ZERO && ye == EXC_ZERO))
      in_exc = EXC_NAN;
    else if (xe == EXC_INF)
      in_exc = EXC_INF;
    else if (xe == EXC_NORM && ye == EXC_ZERO)
      in_exc = EXC_INF;
    else if (xe == EXC_ZERO)
      in_exc = EXC_ZERO;
    else if (ye == EXC_INF)
      in_exc = EXC_ZERO;
    else
      in_spec = 1'b0;
    // NaN is always reported with a positive sign
    in_hdr = {in_exc, (in_exc == EXC_NAN) ? 1'b0 : (X[14] ^ Y[14])};
  end

  logic        ge;
  logic [7:0]  rem_sub;
  logic [6:0]  frac_t;
  logic        guard, sticky, rnd_up;
  logic [7:0]  frac_r;
  logic [8:0]  e_base, e_fin;
  logic [16:0] calc_r;

  always_comb begin
    ge      = rem_q >= {1'b0, sig_y_q};
    rem_sub = ge ? 8'(rem_q - {1'b0, sig_y_q}) : rem_q[7:0];
    if (quo_q[10]) begin
      frac_t = quo_q[9:3];
      guard  = quo_q[2];
      sticky = (|quo_q[1:0]) || (rem_q != 9'd0);
      e_base = {2'b00, ex_q} - {2'b00, ey_q} + 9'd63;
    end else begin
      frac_t = quo_q[8:2];
      guard  = quo_q[1];
      sticky = quo_q[0] || (rem_q != 9'd0);
      e_base = {2'b00, ex_q} - {2'b00, ey_q} + 9'd62;
    end
    rnd_up = guard && (sticky || frac_t[0]);
    frac_r = {1'b0, frac_t} + {7'd0, rnd_up};
    // a rounding carry leaves frac_r[6:0] at zero and bumps the exponent
    e_fin  = e_base + {8'd0, frac_r[7]};
    if (e_fin[8])
      calc_r = {EXC_ZERO, sign_q, 14'd0};
    else if (e_fin[7])
      calc_r = {EXC_INF, sign_q, 14'd0};
    else
      calc_r = {EXC_NORM, sign_q, e_fin[6:0], frac_r[6:0]};
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    sig_y_d    = sig_y_q;
    ex_d       = ex_q;
    ey_d       = ey_q;
    sign_d     = sign_q;
    spec_d     = spec_q;
    spec_hdr_d = spec_hdr_q;
    r_d        = r_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          cnt_d      = 4'd0;
          rem_d      = {2'b01, X[6:0]};
          quo_d      = 11'd0;
          sig_y_d    = {1'b1, Y[6:0]};
          ex_d       = X[13:7];
          ey_d       = Y[13:7];
          sign_d     = X[14] ^ Y[14];
          spec_d     = in_spec;
          spec_hdr_d = in_hdr;
`ifdef FDIV_EARLY_EXIT_EN
          if (in_spec) begin
            state_d = DONE;
            r_d     = {in_hdr, 14'd0};
          end else begin
            state_d = DIV;
          end
`else
          state_d = DIV;
`endif
        end
      end
      DIV: begin
        rem_d = {rem_sub, 1'b0};
        quo_d = {quo_q[9:0], ge};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd10)
          state_d = ROUND;
      end
      ROUND: begin
        r_d     = spec_q ? {spec_hdr_q, 14'd0} : calc_r;
        state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      rem_q      <= 9'd0;
      quo_q      <= 11'd0;
      sig_y_q    <= 8'd0;
      ex_q       <= 7'd0;
      ey_q       <= 7'd0;
      sign_q     <= 1'b0;
      spec_q     <= 1'b0;
      spec_hdr_q <= 3'd0;
      r_q        <= 17'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      sig_y_q    <= sig_y_d;
      ex_q       <= ex_d;
      ey_q       <= ey_d;
      sign_q     <= sign_d;
      spec_q     <= spec_d;
      spec_hdr_q <= spec_hdr_d;
      r_q        <= r_d;
    end
  end

  assign R = r_q;

endmodule

// File: tb/tb_fdiv.sv
// tb_fdiv: scoreboard bench for fdiv; expected results and latencies are queued at accept.
// Honours FDIV_EARLY_EXIT_EN for the special-case latency.
module tb_fdiv;

  logic        clk = 1'b0;
  logic        rst;
  logic [16:0] X, Y, R;
  logic        in_valid, in_ready, out_valid, out_ready;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [16:0] r;
    int          lat;
  } exp_t;

  exp_t sb_q[$];

`ifdef FDIV_EARLY_EXIT_EN
  localparam int SPEC_LAT = 1;
`else
  localparam int SPEC_LAT = 12;
`endif
  localparam int NORM_LAT = 12;

  fdiv #(.ID(1)) dut (
    .clk      (clk),
    .rst      (rst),
    .X        (X),
    .Y        (Y),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .R        (R),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic accept(input logic [16:0] x, input logic [16:0] y);
    int w;
    @(negedge clk);
    X = x;
    Y = y;
    in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("in_ready_wait", (w < 100), 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [16:0] x, input logic [16:0] y,
                        input logic [16:0] r, input int lat, input int hold);
    int   n;
    logic got;
    logic stable;
    exp_t e;
    accept(x, y);
    sb_q.push_back('{r: r, lat: lat});
    n = 0;
    got = 1'b0;
    while (n < 40 && !got) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (out_valid) got = 1'b1;
    end
    e = sb_q.pop_front();
    check({tag, "_timeout"}, got, 1);
    check({tag, "_lat"}, n, e.lat);
    check({tag, "_r"}, R, e.r);
    if (hold > 0) begin
      stable = 1'b1;
      X = 17'h0A040;
      Y = 17'h09F80;
      in_valid = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        if (R !== e.r || in_ready !== 1'b0 || out_valid !== 1'b1) stable = 1'b0;
      end
      in_valid = 1'b0;
      check({tag, "_hold_stable"}, stable, 1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check({tag, "_ov_drop"}, out_valid, 0);
    check({tag, "_in_ready"}, in_ready, 1);
    $display("op %s X=%05h Y=%05h R=%05h exp=%05h lat=%0d", tag, x, y, R, e.r, n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic quiet;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    X = 17'd0;
    Y = 17'd0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_R", R, 17'h00000);
    rst = 1'b0;

    run_op("3div2",     17'h0A040, 17'h0A000, 17'h09FC0, NORM_LAT, 0);
    run_op("1div3",     17'h09F80, 17'h0A040, 17'h09EAB, NORM_LAT, 0);
    run_op("1div1p5",   17'h09F80, 17'h09FC0, 17'h09F2B, NORM_LAT, 0);
    run_op("1div1p75",  17'h09F80, 17'h09FE0, 17'h09F12, NORM_LAT, 0);
    run_op("m3div2",    17'h0E040, 17'h0A000, 17'h0DFC0, NORM_LAT, 0);
    run_op("1div0",     17'h09F80, 17'h00000, 17'h10000, SPEC_LAT, 0);
    run_op("0div0",     17'h00000, 17'h00000, 17'h18000, SPEC_LAT, 0);
    run_op("m1div0",    17'h0DF80, 17'h00000, 17'h14000, SPEC_LAT, 0);
    run_op("minfdinf",  17'h14000, 17'h10000, 17'h18000, SPEC_LAT, 0);
    run_op("m1divinf",  17'h0DF80, 17'h10000, 17'h04000, SPEC_LAT, 0);
    run_op("overflow",  17'h0BF80, 17'h09F00, 17'h10000, NORM_LAT, 0);
    run_op("underflow", 17'h08000, 17'h0A000, 17'h00000, NORM_LAT, 0);
    run_op("backpress", 17'h0A040, 17'h0A000, 17'h09FC0, NORM_LAT, 20);

    // abort an operation mid-divide
    accept(17'h09F80, 17'h0A040);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    quiet = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) quiet = 1'b0;
    end
    check("midrst_no_result", quiet, 1);
    $display("op midrst X=09f80 Y=0a040 aborted");

    run_op("1div1", 17'h09F80, 17'h09F80, 17'h09F80, NORM_LAT, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
